pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, multi-stage pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a per-stage valid bit, a control field and a data field.
- Supports hold (stall) and bubble insertion (flush).
- Replaces the per-boundary hand-written latch blocks with a single configurable block.

Parameters:
- DATA_W, 32, width of the data field (operands, immediate, instruction).
- CTRL_W, 8, width of the control field (ALUSrc, ALUOp, RegDst, MemRd, MemWr, MemtoReg, RegWr, ...).
- STAGES, 1, number of register stages in series; legal range 1..8.
- CLR_DATA_ON_FLUSH, 0, 1 = flush also zeroes the data field; 0 = data field holds its value on flush.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- stall_i  input  1  hold every stage this cycle.
- flush_i  input  1  insert a bubble in every stage this cycle.
- valid_i  input  1  the incoming slot holds a real instruction.
- ctrl_i  input  CTRL_W  incoming control field.
- data_i  input  DATA_W  incoming data field.
- valid_o  output  1  valid bit of the last stage.
- ctrl_o  output  CTRL_W  control field of the last stage.
- data_o  output  DATA_W  data field of the last stage.
- stall_cnt_o  output  CNT_W  stalled-cycle count (present only with PIPE_STAGE_PERF_EN).
- bubble_cnt_o  output  CNT_W  bubble count (present only with PIPE_STAGE_PERF_EN).

Behaviour:
- Stage state: stage k (0..STAGES-1) holds v[k], c[k], d[k]. Stage 0 loads from the inputs; stage k loads from stage k-1. Outputs come directly from stage STAGES-1; there is no combinational path from the inputs to the outputs.
- Reset: rst_i=1 at a clock edge sets all v, c and d to 0. After reset, valid_o=0, ctrl_o=0, data_o=0 and both counters are 0. Reset overrides stall_i and flush_i. Reset asserted mid-stream discards all in-flight entries.
- Priority per edge: rst_i > flush_i > stall_i > advance.
- Flush: every stage gets v=0 and c=0. d is set to 0 if CLR_DATA_ON_FLUSH=1, otherwise d holds. The incoming slot on that cycle is discarded.
- Stall (flush_i=0): every v, c and d holds its value. The incoming slot is not captured; upstream is responsible for holding it.
- Advance (stall_i=0, flush_i=0): all stages shift by one and stage 0 captures valid_i, ctrl_i, data_i.
- Invalid input: when valid_i=0, c[0] is forced to 0 on capture, so an invalid slot never carries write/memory enables. d[0] still captures data_i.
- Latency: exactly STAGES advancing edges from input to output. Stalled edges add no progress.
- Stall and flush asserted together: the flush result applies.
- Occupancy: all STAGES stages may hold valid entries at once. There is no backpressure output; stall_i is the only flow control.
- Bubbles: a bubble is a stage with v=0 and c=0. Downstream qualifies side effects with valid_o or with ctrl_o bits, which are 0 in a bubble.
- STAGES=1: the block behaves as a single enabled register with flush.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o increments on each edge with rst_i=0, stall_i=1, flush_i=0.
  - bubble_cnt_o increments on each edge with rst_i=0 where the last stage loads v=0. This covers a flush, and an advance that shifts an invalid entry into the last stage.
  - Both counters saturate at 2^CNT_W-1 (no wrap) and clear on rst_i.
- Not defined: stall_cnt_o, bubble_cnt_o and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset/latency, STAGES=3: rst_i for 2 cycles, then all outputs are 0. Drive valid_i=1, ctrl_i=8'hA5, data_i=32'h1234_5678 for one edge, then valid_i=0. valid_o=1, ctrl_o=8'hA5, data_o=32'h1234_5678 appear after exactly 3 edges and last 1 cycle; afterwards valid_o=0, ctrl_o=0.
- Stall hold, STAGES=2: inject tokens 32'h1, 32'h2, 32'h3 on consecutive edges with stall_i=1 held for 4 edges after the second token. Outputs freeze at the current values for those 4 edges; output order is 1, 2, 3 with no loss or duplication; token 3 is captured only after stall_i drops.
- Flush beats stall, STAGES=3, CLR_DATA_ON_FLUSH=0: fill all stages with valid data, assert stall_i=1 and flush_i=1 for one edge. Every stage gets v=0 and c=0, and d holds; valid_o=0, ctrl_o=0 and data_o is unchanged. Repeat with CLR_DATA_ON_FLUSH=1: data_o=0.
- Invalid-slot masking: valid_i=0 with ctrl_i=8'hFF. ctrl_o=0 and valid_o=0 after STAGES edges.
- Mid-stream reset, STAGES=4: assert rst_i for one edge while 4 valid entries are in flight and stall_i=1. The next cycle shows valid_o=0, ctrl_o=0, data_o=0, and none of the pre-reset tokens ever emerge.
- PIPE_STAGE_PERF_EN with CNT_W=4: hold stall_i=1 for 20 edges; stall_cnt_o saturates at 15. Issue flush_i for 3 edges; bubble_cnt_o=3. Assert rst_i; both counters read 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: STAGES-deep valid/ctrl/data pipeline register with stall (hold) and flush (bubble).
// Define PIPE_STAGE_PERF_EN to add saturating stall and bubble counters.
module pipe_stage_reg #(
    parameter int DATA_W            = 32,
    parameter int CTRL_W            = 8,
    parameter int STAGES            = 1,
    parameter bit CLR_DATA_ON_FLUSH = 1'b0,
    parameter int CNT_W             = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
`ifdef PIPE_STAGE_PERF_EN
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`else
    output logic [DATA_W-1:0] data_o
`endif
);
    if (STAGES < 1 || STAGES > 8 || CNT_W < 1) begin : g_bad_param
        $error("pipe_stage_reg: STAGES must be 1..8 and CNT_W >= 1");
    end

    logic [STAGES-1:0]             v, vn;
    logic [STAGES-1:0][CTRL_W-1:0] c, cn;
    logic [STAGES-1:0][DATA_W-1:0] d, dn;

    // Next contents on an advancing edge; an invalid slot never carries control bits.
    always_comb begin
        vn[0] = valid_i;
        cn[0] = valid_i ? ctrl_i : {CTRL_W{1'b0}};
        dn[0] = data_i;
        for (int k = 1; k < STAGES; k++) begin
            vn[k] = v[k-1];
            cn[k] = c[k-1];
            dn[k] = d[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v <= '0;
            c <= '0;
            d <= '0;
        end else if (flush_i) begin
            v <= '0;
            c <= '0;
            if (CLR_DATA_ON_FLUSH) d <= '0;
        end else if (!stall_i) begin
            v <= vn;
            c <= cn;
            d <= dn;
        end
    end

    assign valid_o = v[STAGES-1];
    assign ctrl_o  = c[STAGES-1];
    assign data_o  = d[STAGES-1];

`ifdef PIPE_STAGE_PERF_EN
    logic stall_hit, bubble_hit;
    assign stall_hit  = stall_i && !flush_i;
    assign bubble_hit = flush_i || (!stall_i && !vn[STAGES-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_hit && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (bubble_hit && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end
`endif
endmodule
